// File: rtl/shift_issue_queue.sv
// shift_issue_queue
//
// Issue queue in front of an external combinational barrel shifter. Shift
// commands are buffered in a DEPTH-entry circular FIFO; the head entry drives
// the shifter inputs and the shifter's combinational output is captured into
// a single result register with a valid/ready handshake.
//
// Optional feature: define SHIFT_ISSUE_QUEUE_STATS_EN to add a 16-bit
// saturating issue_count output that counts pops (cleared by reset and flush).
//
// Ports
//   clk, rst_n      : clock; synchronous active-low reset
//   flush           : synchronous clear of queue and result register
//   in_valid/ready  : command handshake; in_data, in_amt, in_op
//                     (in_op: 00 SLL, 01 SRL, 10 SLA, 11 SRA)
//   sh_data_in, sh_shift_amt, sh_dir (1=right), sh_arith : to barrel shifter
//   sh_data_out     : combinational result from barrel shifter
//   res_valid/ready : result handshake; res_data
//   issue_count     : (SHIFT_ISSUE_QUEUE_STATS_EN only) saturating pop count
module shift_issue_queue #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SHIFT_AMT_WIDTH = 5,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [SHIFT_AMT_WIDTH-1:0] in_amt,
  input  logic [1:0]                 in_op,
  output logic [DATA_WIDTH-1:0]      sh_data_in,
  output logic [SHIFT_AMT_WIDTH-1:0] sh_shift_amt,
  output logic                       sh_dir,
  output logic                       sh_arith,
  input  logic [DATA_WIDTH-1:0]      sh_data_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data
`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
  ,
  output logic [15:0]                issue_count
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Opcode is decoded at push time so the head drives the shifter directly.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]      data;
    logic [SHIFT_AMT_WIDTH-1:0] amt;
    logic                       dir;
    logic                       arith;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

  logic   push;
  logic   pop;
  logic   not_empty;
  entry_t new_entry;
  entry_t head;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < CntW'(DEPTH));

  // Flush suppresses both sides of the handshake for this cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = not_empty && (!res_valid_q || res_ready) && !flush;

  always_comb begin
    new_entry       = '0;
    new_entry.data  = in_data;
    new_entry.amt   = in_amt;
    new_entry.dir   = in_op[0];
    new_entry.arith = in_op[1];
  end

  assign head = mem_q[rd_ptr_q];

  // Shifter inputs are forced to zero when nothing is queued.
  always_comb begin
    sh_data_in   = '0;
    sh_shift_amt = '0;
    sh_dir       = 1'b0;
    sh_arith     = 1'b0;
    if (not_empty) begin
      sh_data_in   = head.data;
      sh_shift_amt = head.amt;
      sh_dir       = head.dir;
      sh_arith     = head.arith;
    end
  end

  // FIFO storage and pointers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Result register: load on pop, drop on consumption, otherwise hold.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (flush) begin
      res_valid_d = 1'b0;
      res_data_d  = '0;
    end else if (pop) begin
      res_valid_d = 1'b1;
      res_data_d  = sh_data_out;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  // Storage carries no reset; entries are only observed while count_q covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
  logic [15:0] issue_count_q, issue_count_d;

  always_comb begin
    issue_count_d = issue_count_q;
    if (flush) begin
      issue_count_d = '0;
    end else if (pop && (issue_count_q != 16'hFFFF)) begin
      issue_count_d = issue_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_count_q <= '0;
    end else begin
      issue_count_q <= issue_count_d;
    end
  end

  assign issue_count = issue_count_q;
`endif

endmodule

// File: tb/tb_shift_issue_queue.sv
// Self-checking bench for shift_issue_queue. A behavioural barrel shifter
// closes the loop on sh_*; a scoreboard queue holds expected results in
// acceptance order and is compared whenever a result is consumed.
module tb_shift_issue_queue;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_op;
  logic [DW-1:0] sh_data_in;
  logic [AW-1:0] sh_shift_amt;
  logic          sh_dir;
  logic          sh_arith;
  logic [DW-1:0] sh_data_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
  logic [15:0]   issue_count;
`endif

  shift_issue_queue #(
    .DATA_WIDTH     (DW),
    .SHIFT_AMT_WIDTH(AW),
    .DEPTH          (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_amt      (in_amt),
    .in_op       (in_op),
    .sh_data_in  (sh_data_in),
    .sh_shift_amt(sh_shift_amt),
    .sh_dir      (sh_dir),
    .sh_arith    (sh_arith),
    .sh_data_out (sh_data_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
    ,
    .issue_count (issue_count)
`endif
  );

  always #5 clk = ~clk;

  // Downstream barrel shifter.
  always_comb begin
    sh_data_out = '0;
    if (!sh_dir)       sh_data_out = sh_data_in << sh_shift_amt;
    else if (sh_arith) sh_data_out = DW'($signed(sh_data_in) >>> sh_shift_amt);
    else               sh_data_out = sh_data_in >> sh_shift_amt;
  end

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  int unsigned   n_results;
  logic          accepted;
  logic [DW-1:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                          input logic [1:0] op);
    logic signed [DW-1:0] s;
    s = d;
    case (op)
      2'b01:   return d >> a;
      2'b11:   return DW'(s >>> a);
      default: return d << a;
    endcase
  endfunction

  // Bookkeeping on pre-edge values at the falling edge, then advance past the
  // rising edge so callers observe post-edge state.
  task automatic tick();
    accepted = 1'b0;
    @(negedge clk);
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (res_valid && res_ready) begin
        n_results++;
        if (sb.size() == 0) check("unexpected_result", {32'd0, res_data}, 64'hDEAD_0000_0000);
        else check("result", {32'd0, res_data}, {32'd0, sb.pop_front()});
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, in_amt, in_op));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until accepted; leaves in_valid high.
  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [1:0] op);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = accepted;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit done = 0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = (sb.size() == 0) && !res_valid;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0;
    res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_data", {32'd0, res_data}, 64'd0);
    check("rst_sh", {sh_data_in, 25'd0, sh_shift_amt, sh_dir, sh_arith}, 64'd0);

    // SLL 1 by 4, one-cycle latency.
    res_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1; in_amt = 5'd4; in_op = 2'b00;
    tick();
    in_valid = 1'b0;
    check("sll_accepted", {63'd0, accepted}, 64'd1);
    check("sll_head", {sh_data_in, 25'd0, sh_shift_amt, sh_dir, sh_arith},
          {32'h1, 25'd0, 5'd4, 1'b0, 1'b0});
    check("sll_not_yet_valid", {63'd0, res_valid}, 64'd0);
    tick();
    check("sll_valid", {63'd0, res_valid}, 64'd1);
    check("sll_data", {32'd0, res_data}, 64'h10);
    check("sll_head_empty", {32'd0, sh_data_in}, 64'd0);
`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
    check("stats_one", {48'd0, issue_count}, 64'd1);
`endif
    tick();
    check("sll_consumed", {63'd0, res_valid}, 64'd0);

    // SRA, SRL, SLA decode and results.
    send(32'h8000_0000, 5'd31, 2'b11);
    in_valid = 1'b0;
    check("sra_dir_arith", {62'd0, sh_dir, sh_arith}, 64'b11);
    drain();
    send(32'h8000_0000, 5'd4, 2'b01);
    in_valid = 1'b0;
    check("srl_dir_arith", {62'd0, sh_dir, sh_arith}, 64'b10);
    drain();
    send(32'h0000_0003, 5'd2, 2'b10);
    in_valid = 1'b0;
    check("sla_dir_arith", {62'd0, sh_dir, sh_arith}, 64'b01);
    drain();

    // Backpressure: 5 accepted (1 in result register + 4 queued), then full.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'(i + 1), 5'(i), 2'b00);
    in_valid = 1'b0;
    check("bp_full", {63'd0, in_ready}, 64'd0);
    check("bp_valid", {63'd0, res_valid}, 64'd1);
    check("bp_data", {32'd0, res_data}, 64'd1);
    tick(); tick();
    check("bp_hold", {31'd0, res_valid, res_data}, {31'd0, 1'b1, 32'd1});
    in_valid = 1'b1; in_data = 32'hFFFF; in_amt = 5'd1; in_op = 2'b00;
    tick();
    check("bp_reject", {63'd0, accepted}, 64'd0);
    n_results = 0;
    drain();
    check("bp_count", 64'(n_results), 64'd5);

    // Streaming with pointer wrap.
    res_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'hA5A5_0000 | 32'(i); in_amt = 5'(i * 3); in_op = 2'(i);
      tick();
      if (accepted && i > 0 && res_valid) cnt++;
    end
    in_valid = 1'b0;
    tick();
    if (res_valid) cnt++;
    check("stream_cycles", 64'(cnt), 64'd8);
    tick();
    check("stream_done", {63'd0, res_valid}, 64'd0);
    drain();

    // Flush with 3 queued and a pending result.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hF0 + 32'(i), 5'd1, 2'b01);
    in_valid = 1'b0;
    check("pre_flush_valid", {63'd0, res_valid}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", {63'd0, res_valid}, 64'd0);
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    check("flush_sh", {32'd0, sh_data_in}, 64'd0);
`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
    check("flush_stats", {48'd0, issue_count}, 64'd0);
`endif
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("flush_no_old", {63'd0, res_valid}, 64'd0);
    send(32'h0000_0101, 5'd8, 2'b00);
    drain();

    // Reset mid-stream with a full queue.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h1234_0000 + 32'(i), 5'd2, 2'b11);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_sh", {sh_data_in, 25'd0, sh_shift_amt, sh_dir, sh_arith}, 64'd0);
    check("mrst_valid", {63'd0, res_valid}, 64'd0);
    check("mrst_ready", {63'd0, in_ready}, 64'd1);
`ifdef SHIFT_ISSUE_QUEUE_STATS_EN
    check("mrst_stats", {48'd0, issue_count}, 64'd0);
`endif
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mrst_no_result", {63'd0, res_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
